// File: rtl/muxnx1_stream.sv
// muxnx1_stream
// ---------------------------------------------------------------------------
// N-input to 1-output valid/ready stream multiplexer with a registered output
// stage. There are two arbitration modes:
//   mode = 0 : fixed. The channel named by `select` is granted. When select
//              is N or greater, no channel is granted.
//   mode = 1 : round-robin. The first valid channel is granted, searching
//              from ptr upward and wrapping modulo N.
// The output register accepts a new word whenever it is empty or is being
// drained in the same cycle. This sustains one word per cycle.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    N*WIDTH packed words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (at most one bit high)
//   select     channel index used in fixed mode
//   mode       0 = fixed select, 1 = round-robin
//   out_data   registered word from the granted channel
//   out_valid  out_data holds an unconsumed word
//   out_ready  downstream accept
//   out_chan   index of the channel that supplied out_data
// ---------------------------------------------------------------------------
module muxnx1_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      select,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_chan
);

  // N held one bit wider than an index, so that select == N compares correctly
  // when N is a power of two.
  localparam logic [SELW:0]   N_EXT = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST  = SELW'(N-1);

  // Registered state
  logic [SELW-1:0]  ptr_reg;
  logic [SELW-1:0]  ptr_next;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic [SELW-1:0]  chan_reg;
  logic [SELW-1:0]  chan_next;
  logic             valid_reg;
  logic             valid_next;

  // Arbitration results
  logic             fix_hit;
  logic             rr_hit;
  logic [SELW-1:0]  rr_idx;
  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;
  logic             open;
  logic             in_xfer;

  // Unpacked view of the input words, so the selected word is a plain index.
  logic [WIDTH-1:0] chan_data [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // The output register can take a new word if it is empty or is draining now.
  assign open = !valid_reg || out_ready;

  // Fixed mode: the grant does not depend on in_valid. An out-of-range select
  // grants nothing.
  assign fix_hit = ({1'b0, select} < N_EXT);

  // Round-robin search. The loop runs from the farthest offset down to ptr
  // itself. The last hit assigned is therefore the nearest valid channel at
  // or after ptr, in wrapped order. ptr is always below N, so one conditional
  // subtraction performs the modulo.
  always_comb begin
    logic [SELW:0] cand;
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = '0;
    for (int k = N-1; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + (SELW+1)'(k);
      if (cand >= N_EXT) begin
        cand = cand - N_EXT;
      end
      if (in_valid[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand[SELW-1:0];
      end
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (mode) begin
      grant_valid = rr_hit;
      grant_idx   = rr_idx;
    end else begin
      grant_valid = fix_hit;
      grant_idx   = select;
    end
  end

  // in_ready is one-hot on the granted channel. It is held low while reset is
  // asserted, so no handshake can complete during reset.
  generate
    for (gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready[gi] = !rst && open && grant_valid && (grant_idx == SELW'(gi));
    end
  endgenerate

  assign in_xfer = |(in_valid & in_ready);

  // Next-state logic for the pointer and the output stage.
  always_comb begin
    ptr_next   = ptr_reg;
    data_next  = data_reg;
    chan_next  = chan_reg;
    valid_next = valid_reg;

    if (in_xfer) begin
      data_next  = chan_data[grant_idx];
      chan_next  = grant_idx;
      valid_next = 1'b1;
      // The pointer moves only on round-robin transfers. It wraps explicitly at
      // N-1, so a non-power-of-two N never reaches an unused index.
      if (mode) begin
        ptr_next = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
      end
    end else if (valid_reg && out_ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg   <= '0;
      data_reg  <= '0;
      chan_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      ptr_reg   <= ptr_next;
      data_reg  <= data_next;
      chan_reg  <= chan_next;
      valid_reg <= valid_next;
    end
  end

  assign out_data  = data_reg;
  assign out_chan  = chan_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_muxnx1_stream.sv
// tb_muxnx1_stream
// Directed bench for muxnx1_stream. dut uses N=4. dut3 uses N=3, which covers
// an out-of-range select and pointer wrap when N is not a power of two.
// Inputs are driven 1 time unit after the rising edge. Registered outputs are
// checked at that same point, and combinational in_ready is checked at the
// falling edge.
module tb_muxnx1_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  d [4];
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  select;
  logic        mode;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_chan;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  select3;
  logic        mode3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_chan3;

  int checks   = 0;
  int failures = 0;

  assign in_data  = {d[3], d[2], d[1], d[0]};
  assign in_data3 = 24'h33_22_11;

  muxnx1_stream #(.WIDTH(8), .N(4), .SELW(2)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .mode(mode),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan)
  );

  muxnx1_stream #(.WIDTH(8), .N(3), .SELW(2)) dut3 (
    .clk(clk), .rst(rst),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .select(select3), .mode(mode3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_chan(out_chan3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; select = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'hA5; d[3] = 8'h44;
    mode3 = 1'b0; select3 = 2'd0; in_valid3 = 3'b000; out_ready3 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
    checks++; if (out_chan !== 2'd0) begin failures++; $display("FAIL reset_chan got=%0d exp=0", out_chan); end
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    tick();
    rst = 1'b0; in_valid = 4'b0000;
    @(negedge clk);
    checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL post_reset_ready got=%b exp=0001", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid got=%b exp=0", out_valid); end
    $display("reset: outputs cleared, fixed grant ch0 after release");
  endtask

  task automatic test_fixed();
    tick();
    mode = 1'b0; select = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL fixed_ready got=%b exp=0100", in_ready); end
    tick();
    checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL fixed_data got=%h exp=a5", out_data); end
    checks++; if (out_chan !== 2'd2) begin failures++; $display("FAIL fixed_chan got=%0d exp=2", out_chan); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fixed_valid got=%b exp=1", out_valid); end
    in_valid = 4'b0000;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'hA5 || out_chan !== 2'd2) begin failures++; $display("FAIL drain_hold got=%h/%0d exp=a5/2", out_data, out_chan); end
    $display("fixed: select=2 -> a5 on ch2, then drained");
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d;
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_d = d[i % 4];
      checks++; if (out_chan !== 2'(i % 4)) begin failures++; $display("FAIL rr_chan[%0d] got=%0d exp=%0d", i, out_chan, i % 4); end
      checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin failures++; $display("FAIL rr_word[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, exp_d); end
      $display("rr: cycle %0d chan=%0d data=%h", i, out_chan, out_data);
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; select = 2'd1; d[1] = 8'h3C;
    tick();
    checks++; if (out_data !== 8'h3C || out_chan !== 2'd1) begin failures++; $display("FAIL bp_load got=%h/%0d exp=3c/1", out_data, out_chan); end
    out_ready = 1'b0; d[1] = 8'h77; select = 2'd2;
    for (int c = 0; c < 5; c++) begin
      mode = c[0];
      @(negedge clk);
      checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, in_ready); end
      tick();
      checks++; if (out_data !== 8'h3C || out_chan !== 2'd1 || out_valid !== 1'b1) begin
        failures++; $display("FAIL bp_hold[%0d] got=%h/%0d/%b exp=3c/1/1", c, out_data, out_chan, out_valid);
      end
    end
    mode = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL bp_release_ready got=%b exp=0100", in_ready); end
    tick();
    checks++; if (out_data !== 8'hA5 || out_chan !== 2'd2 || out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_release_word got=%h/%0d/%b exp=a5/2/1", out_data, out_chan, out_valid);
    end
    in_valid = 4'b0000;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    $display("backpressure: 3c held 5 cycles, a5 loaded on release");
  endtask

  task automatic test_wrap();
    mode = 1'b1; in_valid = 4'b0100; out_ready = 1'b1;
    tick();
    checks++; if (out_chan !== 2'd2) begin failures++; $display("FAIL wrap_setup got=%0d exp=2", out_chan); end
    in_valid = 4'b0101;
    @(negedge clk);
    checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL wrap_ready got=%b exp=0001", in_ready); end
    tick();
    checks++; if (out_chan !== 2'd0 || out_data !== 8'h11) begin failures++; $display("FAIL wrap_first got=%0d/%h exp=0/11", out_chan, out_data); end
    tick();
    checks++; if (out_chan !== 2'd2 || out_data !== 8'hA5) begin failures++; $display("FAIL wrap_second got=%0d/%h exp=2/a5", out_chan, out_data); end
    in_valid = 4'b1111;
    tick();
    checks++; if (out_chan !== 2'd3) begin failures++; $display("FAIL wrap_ptr3 got=%0d exp=3", out_chan); end
    in_valid = 4'b0000;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wrap_drain got=%b exp=0", out_valid); end
    $display("wrap: ch2, ch0, ch2, ch3 served");
  endtask

  task automatic test_invalid_select();
    logic [7:0] exp_d;
    mode3 = 1'b0; select3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    @(negedge clk);
    checks++; if (in_ready3 !== 3'b000) begin failures++; $display("FAIL badsel_ready got=%b exp=000", in_ready3); end
    tick();
    checks++; if (out_valid3 !== 1'b0) begin failures++; $display("FAIL badsel_valid got=%b exp=0", out_valid3); end
    tick();
    checks++; if (out_valid3 !== 1'b0) begin failures++; $display("FAIL badsel_valid2 got=%b exp=0", out_valid3); end
    mode3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_d = 8'h11 * 8'(i % 3 + 1);
      checks++; if (out_chan3 !== 2'(i % 3) || out_data3 !== exp_d) begin
        failures++; $display("FAIL n3_rr[%0d] got=%0d/%h exp=%0d/%h", i, out_chan3, out_data3, i % 3, exp_d);
      end
    end
    in_valid3 = 3'b000; mode3 = 1'b0;
    tick();
    $display("n3: select=3 ignored, rr 0,1,2,0");
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b0; d[1] = 8'h77;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h77 || out_chan !== 2'd1) begin
      failures++; $display("FAIL mid_load got=%b/%h/%0d exp=1/77/1", out_valid, out_data, out_chan);
    end
    in_valid = 4'b1111; out_ready = 1'b1;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
      failures++; $display("FAIL mid_async got=%b/%h/%0d exp=0/00/0", out_valid, out_data, out_chan);
    end
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL mid_ready got=%b exp=0000", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_held got=%b exp=0", out_valid); end
    rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'h11) begin
      failures++; $display("FAIL mid_first got=%b/%0d/%h exp=1/0/11", out_valid, out_chan, out_data);
    end
    $display("reset_mid: word discarded, ch0 granted first after release");
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_invalid_select();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
